parking_gate_arbiter: RTL and testbench
=======================================

// Module: parking_gate_arbiter
// PURPOSE
//   Controller for the single shared barrier gate of the car park. Arbitrates between
//   entry and exit lane requests and checks the entry password. Sequences the gate
//   open/close timing and owns the occupancy counter that drives the display and space logic.
// PARAMETERS
//   CAPACITY     8      max cars; entry refused when count_cars == CAPACITY
//   CNT_W        4      width of count_cars; must hold CAPACITY
//   PASS_1       2'b01  required password_1 value
//   PASS_2       2'b10  required password_2 value
//   OPEN_CYCLES  4      cycles gate_open stays high per grant (>=1)
//   LOCK_CYCLES  16     entry lockout duration, used only with PARK_LOCKOUT_EN
// PORTS
//   clk          in   1      system clock, rising edge
//   rst_n        in   1      asynchronous, active-low reset
//   sense_entry  in   1      level; car waiting at entry sensor
//   sense_exit   in   1      level; car waiting at exit sensor
//   pwd_valid    in   1      one-cycle strobe; password_1/2 valid this cycle
//   password_1   in   2      password digit 1
//   password_2   in   2      password digit 2
//   gate_open    out  1      barrier raised
//   gate_dir     out  1      0 = serving entry, 1 = serving exit
//   green_light  out  1      car may pass
//   red_light    out  1      car must wait / refused
//   count_cars   out  CNT_W  current occupancy
//   full         out  1      count_cars == CAPACITY
//   empty        out  1      count_cars == 0
//   pwd_error    out  1      one-cycle pulse on password mismatch
//   lockout      out  1      entry locked out (always 0 without PARK_LOCKOUT_EN)
// BEHAVIOUR
//   - All outputs registered. Reset: FSM=IDLE; count_cars=0, empty=1; every other output 0.
//   - Reset asserted mid-operation: gate closes and count clears asynchronously.
//   - FSM states: IDLE, WAIT_PWD, OPEN_ENT, OPEN_EXT, CLOSE.
//   - Eligibility: entry is eligible when sense_entry & !full & !lockout.
//     Exit is eligible when sense_exit & !empty.
//   - IDLE arbitration when both lanes are eligible:
//       - if full, exit wins;
//       - otherwise round-robin, where the lane opposite last_grant wins. last_grant resets to exit.
//   - IDLE, entry only eligible: next cycle WAIT_PWD, gate_dir=0, red_light=1.
//   - IDLE, exit only eligible: next cycle OPEN_EXT, gate_dir=1.
//   - IDLE, sense_entry while full or locked out: red_light=1, state stays IDLE.
//     Otherwise both lights are 0 in IDLE.
//   - WAIT_PWD, pwd_valid with both digits matching: next cycle OPEN_ENT.
//   - WAIT_PWD, pwd_valid with a mismatch: pwd_error pulses next cycle, state stays WAIT_PWD.
//   - WAIT_PWD, sense_entry drops: return to IDLE, count unchanged.
//   - OPEN_ENT/OPEN_EXT: gate_open=1, green_light=1, red_light=0 for exactly OPEN_CYCLES cycles.
//     Latency: a matching pwd_valid at cycle t gives gate_open high in cycles t+1 .. t+OPEN_CYCLES.
//   - Count update happens once, on the last open cycle:
//       - OPEN_ENT: +1, saturating at CAPACITY;
//       - OPEN_EXT: -1, saturating at 0.
//     full and empty update in the same cycle as count_cars.
//   - CLOSE: gate_open=0 and lights 0. Stays in CLOSE until the served lane's sense input
//     is low (one car = one count), then goes to IDLE.
//   - Sense inputs on the unserved lane are ignored outside IDLE; they are not queued.
// CONFIGURATION
//   - PARK_LOCKOUT_EN defined:
//       - a 2-bit consecutive-mismatch counter, cleared by a correct password;
//       - the 3rd consecutive mismatch forces WAIT_PWD->IDLE and loads a lock timer with LOCK_CYCLES;
//       - lockout=1 while the timer is nonzero; the timer counts down every cycle;
//       - exits continue to be served during lockout.
//   - PARK_LOCKOUT_EN undefined: no counter or timer, lockout tied 0, unlimited retries.
// STRUCTURE
//   - Package parking_pkg holds:
//       - the FSM state typedef (enum for IDLE..CLOSE);
//       - lane encoding constants LANE_ENTRY=1'b0, LANE_EXIT=1'b1;
//       - default PASS_1/PASS_2 constants.
//   - One sub-module, parking_gate_timer: loadable down-counter, with the load value as a
//     parameter. It is instanced for the open window, and a second time under
//     PARK_LOCKOUT_EN for the lockout timer.
// TESTING
//   - Reset, then sense_entry=1 and pwd_valid with 01/10:
//     gate_open high 4 cycles, gate_dir=0, count 0->1, empty 1->0.
//   - Wrong password (01/01): pwd_error pulses, red_light stays 1, gate_open stays 0, count unchanged.
//   - Count=8 (full), sense_entry and sense_exit both high: exit served first, count 8->7;
//     red_light high while entry is refused.
//   - Count=3, both lanes requesting continuously with last_grant=exit: grants alternate
//     entry, exit, entry; count goes 3->4->3->4.
//   - rst_n low during OPEN_ENT: gate_open=0 and count=0 immediately.
//     After release the FSM is in IDLE.
//   - PARK_LOCKOUT_EN: three mismatches give lockout=1 for 16 cycles, entry ignored,
//     an exit is still served; lockout returns to 0 after 16 cycles.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared types and constants for the car-park gate controller: FSM state encoding,
// lane encoding and the default entry password digits.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_PWD = 3'd1,
    OPEN_ENT = 3'd2,
    OPEN_EXT = 3'd3,
    CLOSE    = 3'd4
  } state_e;

  localparam logic LANE_ENTRY = 1'b0;
  localparam logic LANE_EXIT  = 1'b1;

  localparam logic [1:0] PASS_1_DEF = 2'b01;
  localparam logic [1:0] PASS_2_DEF = 2'b10;

  function automatic logic is_open(input state_e s);
    return (s == OPEN_ENT) || (s == OPEN_EXT);
  endfunction

endpackage

// File: rtl/parking_gate_timer.sv
// Loadable down-counter. `active` is registered and is high while the count is nonzero;
// loading LOAD_VAL makes it high from the next cycle for exactly LOAD_VAL cycles.
module parking_gate_timer
  import parking_pkg::*;
#(
  parameter int unsigned LOAD_VAL = 4,
  parameter int unsigned W        = (LOAD_VAL < 1) ? 1 : $clog2(LOAD_VAL + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic active
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         active_q, active_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = W'(LOAD_VAL);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
    active_d = (cnt_d != '0);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign active = active_q;

endmodule

// File: rtl/parking_gate_arbiter.sv
// Shared barrier-gate controller: entry/exit arbitration, password check, open timing
// and occupancy count. Optional entry lockout after 3 bad passwords: define PARK_LOCKOUT_EN.
module parking_gate_arbiter
  import parking_pkg::*;
#(
  parameter int unsigned CAPACITY    = 8,
  parameter int unsigned CNT_W       = 4,
  parameter logic [1:0]  PASS_1      = PASS_1_DEF,
  parameter logic [1:0]  PASS_2      = PASS_2_DEF,
  parameter int unsigned OPEN_CYCLES = 4,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sense_entry,
  input  logic             sense_exit,
  input  logic             pwd_valid,
  input  logic [1:0]       password_1,
  input  logic [1:0]       password_2,
  output logic             gate_open,
  output logic             gate_dir,
  output logic             green_light,
  output logic             red_light,
  output logic [CNT_W-1:0] count_cars,
  output logic             full,
  output logic             empty,
  output logic             pwd_error,
  output logic             lockout
);

  localparam logic [CNT_W-1:0] CAP_VAL = CNT_W'(CAPACITY);

  state_e           state_q, state_d;
  logic             gate_dir_q, gate_dir_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             gate_open_q, gate_open_d;
  logic             green_q, green_d;
  logic             red_q, red_d;
  logic             pwd_error_q, pwd_error_d;

  logic open_load, open_active;
  logic lockout_i, lock_next;
  logic entry_ok, exit_ok, pwd_ok, entry_wins;

  parking_gate_timer #(.LOAD_VAL(OPEN_CYCLES - 1)) u_open_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (open_load),
    .active (open_active)
  );

`ifdef PARK_LOCKOUT_EN
  logic [1:0] mis_cnt_q, mis_cnt_d;
  logic       lock_load;

  parking_gate_timer #(.LOAD_VAL(LOCK_CYCLES)) u_lock_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (lock_load),
    .active (lockout_i)
  );

  // Lockout as it will be seen next cycle; used for the registered red light.
  assign lock_next = lock_load | lockout_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mis_cnt_q <= '0;
    else        mis_cnt_q <= mis_cnt_d;
  end
`else
  assign lockout_i = 1'b0;
  assign lock_next = 1'b0;
`endif

  assign entry_ok = sense_entry & ~full_q & ~lockout_i;
  assign exit_ok  = sense_exit & ~empty_q;
  assign pwd_ok   = (password_1 == PASS_1) && (password_2 == PASS_2);
  // A full car park already makes entry ineligible, so only the round-robin case remains.
  assign entry_wins = entry_ok & (~exit_ok | (last_grant_q == LANE_EXIT));

  always_comb begin
    state_d      = state_q;
    gate_dir_d   = gate_dir_q;
    last_grant_d = last_grant_q;
    count_d      = count_q;
    pwd_error_d  = 1'b0;
`ifdef PARK_LOCKOUT_EN
    mis_cnt_d    = mis_cnt_q;
    lock_load    = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (entry_wins) begin
          state_d      = WAIT_PWD;
          gate_dir_d   = LANE_ENTRY;
          last_grant_d = LANE_ENTRY;
        end else if (exit_ok) begin
          state_d      = OPEN_EXT;
          gate_dir_d   = LANE_EXIT;
          last_grant_d = LANE_EXIT;
        end
      end
      WAIT_PWD: begin
        if (!sense_entry) begin
          state_d = IDLE;
        end else if (pwd_valid) begin
          if (pwd_ok) begin
            state_d = OPEN_ENT;
`ifdef PARK_LOCKOUT_EN
            mis_cnt_d = '0;
`endif
          end else begin
            pwd_error_d = 1'b1;
`ifdef PARK_LOCKOUT_EN
            if (mis_cnt_q == 2'd2) begin
              mis_cnt_d = '0;
              lock_load = 1'b1;
              state_d   = IDLE;
            end else begin
              mis_cnt_d = mis_cnt_q + 2'd1;
            end
`endif
          end
        end
      end
      OPEN_ENT: begin
        if (!open_active) begin
          state_d = CLOSE;
          if (count_q < CAP_VAL) count_d = count_q + 1'b1;
        end
      end
      OPEN_EXT: begin
        if (!open_active) begin
          state_d = CLOSE;
          if (count_q != '0) count_d = count_q - 1'b1;
        end
      end
      CLOSE: begin
        // Wait for the served car to clear its sensor so one car counts once.
        if (gate_dir_q == LANE_ENTRY ? !sense_entry : !sense_exit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    full_d      = (count_d == CAP_VAL);
    empty_d     = (count_d == '0);
    gate_open_d = is_open(state_d);
    green_d     = gate_open_d;
    red_d       = (state_d == WAIT_PWD) |
                  ((state_d == IDLE) & sense_entry & (full_d | lock_next));
    open_load   = is_open(state_d) & ~is_open(state_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gate_dir_q   <= LANE_ENTRY;
      last_grant_q <= LANE_EXIT;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      gate_open_q  <= 1'b0;
      green_q      <= 1'b0;
      red_q        <= 1'b0;
      pwd_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      gate_dir_q   <= gate_dir_d;
      last_grant_q <= last_grant_d;
      count_q      <= count_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      gate_open_q  <= gate_open_d;
      green_q      <= green_d;
      red_q        <= red_d;
      pwd_error_q  <= pwd_error_d;
    end
  end

  assign gate_open   = gate_open_q;
  assign gate_dir    = gate_dir_q;
  assign green_light = green_q;
  assign red_light   = red_q;
  assign count_cars  = count_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign pwd_error   = pwd_error_q;
  assign lockout     = lockout_i;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Self-checking bench for parking_gate_arbiter: directed scenarios plus randomized lane
// traffic checked against a transaction-level occupancy/arbitration model.
module tb_parking_gate_arbiter;

  localparam int CAP      = 8;
  localparam int CNT_W    = 4;
  localparam int OPEN_CYC = 4;
  localparam int LOCK_CYC = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sense_entry = 1'b0;
  logic             sense_exit = 1'b0;
  logic             pwd_valid = 1'b0;
  logic [1:0]       password_1 = 2'b00;
  logic [1:0]       password_2 = 2'b00;
  logic             gate_open, gate_dir, green_light, red_light;
  logic [CNT_W-1:0] count_cars;
  logic             full, empty, pwd_error, lockout;

  int checks = 0;
  int failures = 0;
  int model_count = 0;
  bit model_last_exit = 1'b1;

  parking_gate_arbiter #(
    .CAPACITY(CAP), .CNT_W(CNT_W), .PASS_1(2'b01), .PASS_2(2'b10),
    .OPEN_CYCLES(OPEN_CYC), .LOCK_CYCLES(LOCK_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sense_entry(sense_entry), .sense_exit(sense_exit),
    .pwd_valid(pwd_valid), .password_1(password_1), .password_2(password_2),
    .gate_open(gate_open), .gate_dir(gate_dir), .green_light(green_light),
    .red_light(red_light), .count_cars(count_cars), .full(full), .empty(empty),
    .pwd_error(pwd_error), .lockout(lockout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bad_pwd();
    logic [1:0] p1, p2;
    do begin
      p1 = 2'($urandom_range(0, 3));
      p2 = 2'($urandom_range(0, 3));
    end while (p1 == 2'b01 && p2 == 2'b10);
    password_1 = p1;
    password_2 = p2;
  endtask

  // Expects to be in the WAIT_PWD phase: entry lane selected, red shown, gate shut.
  task automatic check_waiting(input string tag);
    checks++;
    if ({gate_open, gate_dir, green_light, red_light} !== 4'b0001) begin
      failures++;
      $display("FAIL %s_wait: open/dir/green/red got %b expected 0001", tag,
               {gate_open, gate_dir, green_light, red_light});
    end
  endtask

  // Called in the first open cycle; checks the full window and the count update after it.
  task automatic check_open_window(input bit dir, input string tag);
    for (int i = 0; i < OPEN_CYC; i++) begin
      checks++;
      if ({gate_open, gate_dir, green_light, red_light} !== {1'b1, dir, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL %s_open%0d: open/dir/green/red got %b expected %b", tag, i,
                 {gate_open, gate_dir, green_light, red_light}, {1'b1, dir, 1'b1, 1'b0});
      end
      checks++;
      if (count_cars !== CNT_W'(model_count)) begin
        failures++;
        $display("FAIL %s_cnt_hold%0d: count got %0d expected %0d", tag, i, count_cars, model_count);
      end
      tick();
    end
    if (dir) model_count = (model_count > 0) ? model_count - 1 : 0;
    else     model_count = (model_count < CAP) ? model_count + 1 : CAP;
    checks++;
    if ({gate_open, green_light, red_light} !== 3'b000) begin
      failures++;
      $display("FAIL %s_closed: open/green/red got %b expected 000", tag,
               {gate_open, green_light, red_light});
    end
    checks++;
    if ({count_cars, full, empty} !== {CNT_W'(model_count), model_count == CAP, model_count == 0}) begin
      failures++;
      $display("FAIL %s_count: count/full/empty got %0d/%b/%b expected %0d/%b/%b", tag,
               count_cars, full, empty, model_count, model_count == CAP, model_count == 0);
    end
  endtask

  // In WAIT_PWD: nbad wrong passwords, then the right one and the open window.
  task automatic serve_pwd(input int nbad, input string tag);
    for (int k = 0; k < nbad; k++) begin
      set_bad_pwd();
      pwd_valid = 1'b1;
      tick();
      pwd_valid = 1'b0;
      checks++;
      if ({pwd_error, red_light, gate_open} !== 3'b110) begin
        failures++;
        $display("FAIL %s_badpwd%0d: err/red/open got %b expected 110", tag, k,
                 {pwd_error, red_light, gate_open});
      end
      tick();
      checks++;
      if ({pwd_error, red_light, gate_open} !== 3'b010) begin
        failures++;
        $display("FAIL %s_errpulse%0d: err/red/open got %b expected 010", tag, k,
                 {pwd_error, red_light, gate_open});
      end
    end
    password_1 = 2'b01;
    password_2 = 2'b10;
    pwd_valid  = 1'b1;
    tick();
    pwd_valid  = 1'b0;
    check_open_window(1'b0, tag);
  endtask

  task automatic entry_txn(input int nbad, input string tag);
    sense_entry = 1'b1;
    tick();
    model_last_exit = 1'b0;
    check_waiting(tag);
    serve_pwd(nbad, tag);
    sense_entry = 1'b0;
    tick();
  endtask

  task automatic exit_txn(input string tag);
    sense_exit = 1'b1;
    tick();
    model_last_exit = 1'b1;
    check_open_window(1'b1, tag);
    sense_exit = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    checks++;
    if ({gate_open, gate_dir, green_light, red_light, pwd_error, lockout, full, empty} !== 8'b00000001) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 00000001",
               {gate_open, gate_dir, green_light, red_light, pwd_error, lockout, full, empty});
    end
    checks++;
    if (count_cars !== '0) begin
      failures++;
      $display("FAIL reset_count: got %0d expected 0", count_cars);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if ({gate_open, red_light, green_light, count_cars} !== {3'b000, CNT_W'(0)}) begin
      failures++;
      $display("FAIL reset_idle: open/red/green/count got %b expected 0", {gate_open, red_light, green_light, count_cars});
    end
    model_count     = 0;
    model_last_exit = 1'b1;
  endtask

  task automatic test_entry_basic();
    entry_txn(0, "entry_basic");
  endtask

  task automatic test_wrong_password();
    sense_entry = 1'b1;
    tick();
    model_last_exit = 1'b0;
    check_waiting("wrong_pwd");
    password_1 = 2'b01;
    password_2 = 2'b01;
    pwd_valid  = 1'b1;
    tick();
    pwd_valid  = 1'b0;
    checks++;
    if ({pwd_error, red_light, gate_open, count_cars} !== {3'b110, CNT_W'(model_count)}) begin
      failures++;
      $display("FAIL wrong_pwd_err: err/red/open/count got %b expected %b",
               {pwd_error, red_light, gate_open, count_cars}, {3'b110, CNT_W'(model_count)});
    end
    tick();
    checks++;
    if ({pwd_error, red_light, gate_open} !== 3'b010) begin
      failures++;
      $display("FAIL wrong_pwd_pulse: err/red/open got %b expected 010", {pwd_error, red_light, gate_open});
    end
    serve_pwd(0, "wrong_pwd_retry");
    sense_entry = 1'b0;
    tick();
  endtask

  task automatic test_full_exit_priority();
    while (model_count < CAP) entry_txn(0, "fill");
    sense_entry = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({full, red_light, gate_open, count_cars} !== {3'b110, CNT_W'(CAP)}) begin
        failures++;
        $display("FAIL full_refuse%0d: full/red/open/count got %b expected %b", i,
                 {full, red_light, gate_open, count_cars}, {3'b110, CNT_W'(CAP)});
      end
    end
    sense_exit = 1'b1;
    tick();
    model_last_exit = 1'b1;
    check_open_window(1'b1, "full_exit");
    sense_exit  = 1'b0;
    sense_entry = 1'b0;
    tick();
  endtask

  // Both lanes keep requesting; the served car clears its sensor for one cycle between grants.
  task automatic both_lanes_round(input int ngrants, input bit random_pwd, input string tag);
    bit win_exit;
    sense_entry = 1'b1;
    sense_exit  = 1'b1;
    for (int g = 0; g < ngrants; g++) begin
      tick();
      win_exit = (model_count >= CAP) || ((model_count > 0) && !model_last_exit);
      model_last_exit = win_exit;
      if (win_exit) begin
        check_open_window(1'b1, tag);
        sense_exit = 1'b0;
        tick();
        sense_exit = 1'b1;
      end else begin
        check_waiting(tag);
        serve_pwd(random_pwd ? $urandom_range(0, 2) : 0, tag);
        sense_entry = 1'b0;
        tick();
        sense_entry = 1'b1;
      end
    end
    sense_entry = 1'b0;
    sense_exit  = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    while (model_count > 3) exit_txn("drain");
    checks++;
    if (count_cars !== CNT_W'(3) || model_last_exit !== 1'b1) begin
      failures++;
      $display("FAIL rr_setup: count got %0d expected 3", count_cars);
    end
    both_lanes_round(3, 1'b0, "round_robin");
  endtask

  task automatic test_random();
    int op;
    for (int n = 0; n < 30; n++) begin
      op = $urandom_range(0, 3);
      if (op == 0) begin
        if (model_count < CAP) begin
          entry_txn($urandom_range(0, 2), "rand_entry");
        end else begin
          sense_entry = 1'b1;
          tick();
          checks++;
          if ({red_light, gate_open} !== 2'b10) begin
            failures++;
            $display("FAIL rand_full_refuse: red/open got %b expected 10", {red_light, gate_open});
          end
          sense_entry = 1'b0;
          tick();
        end
      end else if (op == 1) begin
        if (model_count > 0) begin
          exit_txn("rand_exit");
        end else begin
          sense_exit = 1'b1;
          repeat (2) begin
            tick();
            checks++;
            if ({red_light, gate_open, empty} !== 3'b001) begin
              failures++;
              $display("FAIL rand_empty_refuse: red/open/empty got %b expected 001", {red_light, gate_open, empty});
            end
          end
          sense_exit = 1'b0;
          tick();
        end
      end else begin
        both_lanes_round(1, 1'b1, "rand_both");
      end
    end
  endtask

`ifdef PARK_LOCKOUT_EN
  task automatic test_lockout();
    int lock_hi;
    bit saw_exit, saw_entry_open;
    if (model_count == 0) entry_txn(0, "lock_prep");
    sense_entry = 1'b1;
    tick();
    model_last_exit = 1'b0;
    check_waiting("lock");
    for (int k = 0; k < 3; k++) begin
      set_bad_pwd();
      pwd_valid = 1'b1;
      tick();
      pwd_valid = 1'b0;
      if (k < 2) tick();
    end
    checks++;
    if ({lockout, pwd_error, gate_open} !== 3'b110) begin
      failures++;
      $display("FAIL lock_start: lockout/err/open got %b expected 110", {lockout, pwd_error, gate_open});
    end
    sense_exit = 1'b1;
    lock_hi = 1;
    saw_exit = 1'b0;
    saw_entry_open = 1'b0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (gate_open && gate_dir) saw_exit = 1'b1;
      if (gate_open && !gate_dir) saw_entry_open = 1'b1;
      if (saw_exit && !gate_open && sense_exit) sense_exit = 1'b0;
      if (!lockout) break;
      lock_hi++;
      if (lock_hi == LOCK_CYC - 2) begin
        checks++;
        if ({red_light, gate_open} !== 2'b10) begin
          failures++;
          $display("FAIL lock_red: red/open got %b expected 10", {red_light, gate_open});
        end
      end
    end
    model_count = (model_count > 0) ? model_count - 1 : 0;
    model_last_exit = 1'b1;
    checks++;
    if (lock_hi !== LOCK_CYC) begin
      failures++;
      $display("FAIL lock_len: lockout cycles got %0d expected %0d", lock_hi, LOCK_CYC);
    end
    checks++;
    if ({saw_exit, saw_entry_open} !== 2'b10) begin
      failures++;
      $display("FAIL lock_service: exit_served/entry_opened got %b expected 10", {saw_exit, saw_entry_open});
    end
    checks++;
    if (count_cars !== CNT_W'(model_count)) begin
      failures++;
      $display("FAIL lock_count: count got %0d expected %0d", count_cars, model_count);
    end
    tick();
    model_last_exit = 1'b0;
    check_waiting("lock_release");
    serve_pwd(0, "lock_release");
    sense_entry = 1'b0;
    tick();
  endtask
`else
  task automatic test_unlimited_retries();
    entry_txn(4, "retries");
    checks++;
    if (lockout !== 1'b0) begin
      failures++;
      $display("FAIL retries_lockout: got %b expected 0", lockout);
    end
  endtask
`endif

  task automatic test_reset_mid_open();
    if (model_count == 0) entry_txn(0, "mid_prep");
    sense_entry = 1'b1;
    tick();
    check_waiting("mid_reset");
    password_1 = 2'b01;
    password_2 = 2'b10;
    pwd_valid  = 1'b1;
    tick();
    pwd_valid  = 1'b0;
    checks++;
    if (gate_open !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_opened: gate_open got %b expected 1", gate_open);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gate_open, green_light, count_cars, empty} !== {2'b00, CNT_W'(0), 1'b1}) begin
      failures++;
      $display("FAIL mid_reset_async: open/green/count/empty got %b expected 0000001",
               {gate_open, green_light, count_cars, empty});
    end
    model_count     = 0;
    model_last_exit = 1'b1;
    sense_entry = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    checks++;
    if ({gate_open, red_light, green_light, count_cars} !== {3'b000, CNT_W'(0)}) begin
      failures++;
      $display("FAIL mid_reset_idle: open/red/green/count got %b expected 0",
               {gate_open, red_light, green_light, count_cars});
    end
    entry_txn(0, "post_reset");
  endtask

  initial begin
    test_reset();
    test_entry_basic();
    test_wrong_password();
    test_full_exit_priority();
    test_round_robin();
    test_random();
`ifdef PARK_LOCKOUT_EN
    test_lockout();
`else
    test_unlimited_retries();
`endif
    test_reset_mid_open();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
